// File: rtl/can_wb_reg_bridge.sv
// ---------------------------------------------------------------------------
// can_wb_reg_bridge
//
// Wishbone-classic slave front end for the CAN controller register file.
// It turns each host bus cycle into a single-cycle write strobe (reg_we) or
// read strobe (reg_re). The address and write data are latched so they stay
// stable while the register file uses them. Read data is captured at the end
// of the strobe cycle and returned with a one-cycle wb_ack_o.
//
// Access timeline with W = WAIT_STATES (edge 0 samples the request):
//   cycle 1+W : reg_we / reg_re   (only for addresses below NUM_REGS)
//   cycle 2+W : wb_ack_o, with wb_dat_o valid
//   An access therefore occupies at least 3+W cycles.
//
// Ports
//   clk, rst_n  : controller clock; asynchronous active-low reset
//   wb_cyc_i    : bus cycle valid
//   wb_stb_i    : strobe (ignored unless wb_cyc_i is also high)
//   wb_we_i     : 1 = write, 0 = read
//   wb_adr_i    : register address
//   wb_dat_i    : write data
//   wb_dat_o    : read data; holds its value until the next strobe cycle
//   wb_ack_o    : single-cycle acknowledge
//   reg_addr    : latched address to the register file
//   reg_wdata   : latched write data to the register file
//   reg_we      : one-cycle write strobe
//   reg_re      : one-cycle read strobe (triggers read-clear side effects)
//   reg_rdata   : combinational read data for reg_addr
// ---------------------------------------------------------------------------
module can_wb_reg_bridge #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REGS    = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [DATA_WIDTH-1:0] reg_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STROBE = 2'd2,
    ACK    = 2'd3
  } state_t;

  // The counter is preloaded with W-1, so WAIT lasts exactly W cycles.
  localparam int              WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]      WAIT_LOAD   = WAIT_LOAD_I[3:0];
  // One extra bit lets NUM_REGS = 2**ADDR_WIDTH be represented.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic                   mapped_q, mapped_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic [DATA_WIDTH-1:0]  dat_d;
  logic                   reg_we_d, reg_re_d, ack_d;

  logic req;
  logic adr_mapped;

  assign req        = wb_cyc_i & wb_stb_i;
  assign adr_mapped = ({1'b0, wb_adr_i} < NUM_REGS_W);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking (<=) assignments so that every
  // flop samples values from before the edge, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: each combinational block assigns a default to every signal first.
  // Without the default, a path that skips the assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = (WAIT_STATES > 0) ? WAIT : STROBE;
      end
      WAIT: begin
        if (!wb_cyc_i)        state_d = IDLE;   // master gave up: no strobe
        else if (cnt_q == '0) state_d = STROBE;
      end
      // The strobe is already committed here. Only the ack depends on cyc.
      STROBE:  state_d = wb_cyc_i ? ACK : IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values (registered below)
  // -------------------------------------------------------------------------
  always_comb begin
    addr_d   = reg_addr;
    wdata_d  = reg_wdata;
    we_d     = we_q;
    mapped_d = mapped_q;
    cnt_d    = cnt_q;
    dat_d    = wb_dat_o;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d   = wb_adr_i;
          wdata_d  = wb_dat_i;
          we_d     = wb_we_i;
          mapped_d = adr_mapped;
          cnt_d    = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
      end
      STROBE: begin
        // Capture read data for mapped reads only. Writes and unmapped
        // accesses return zero.
        dat_d = (!we_q && mapped_q) ? reg_rdata : '0;
      end
      default: ;
    endcase

    // The strobes are registered, so they are decoded from the state being
    // entered. We_d and mapped_d already select between the live bus fields
    // (coming from IDLE) and the latched copies (coming from WAIT).
    reg_we_d = (state_d == STROBE) &&  we_d && mapped_d;
    reg_re_d = (state_d == STROBE) && !we_d && mapped_d;
    ack_d    = (state_d == ACK);
  end

  // -------------------------------------------------------------------------
  // Output and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      we_q      <= 1'b0;
      mapped_q  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      wb_dat_o  <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      wb_ack_o  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      mapped_q  <= mapped_d;
      reg_addr  <= addr_d;
      reg_wdata <= wdata_d;
      wb_dat_o  <= dat_d;
      reg_we    <= reg_we_d;
      reg_re    <= reg_re_d;
      wb_ack_o  <= ack_d;
    end
  end

endmodule

// File: tb/tb_can_wb_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_can_wb_reg_bridge
//
// Directed bench with two instances: u_w0 (WAIT_STATES = 0) and u_w3
// (WAIT_STATES = 3), each driven by its own bus signals. Inputs change 1 ns
// after the rising edge. Outputs are sampled at that same point, before any
// input changes. "Cycle n" is the interval after edge n, where edge 0 is the
// edge that samples the request.
// ---------------------------------------------------------------------------
module tb_can_wb_reg_bridge;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Bus signals for the zero-wait-state instance
  logic       a_cyc, a_stb, a_we;
  logic [7:0] a_adr, a_dat, a_dat_o, a_raddr, a_wdata, a_rdata;
  logic       a_ack, a_rwe, a_rre;

  // Bus signals for the three-wait-state instance
  logic       b_cyc, b_stb, b_we;
  logic [7:0] b_adr, b_dat, b_dat_o, b_raddr, b_wdata, b_rdata;
  logic       b_ack, b_rwe, b_rre;

  // Register-file read model: 0x3C at address 2, otherwise {a[3:0], ~a[3:0]}
  function automatic logic [7:0] rd_model(input logic [7:0] a);
    if (a == 8'h02) return 8'h3C;
    return {a[3:0], ~a[3:0]};
  endfunction

  assign a_rdata = rd_model(a_raddr);
  assign b_rdata = rd_model(b_raddr);

  can_wb_reg_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_REGS(32), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(a_cyc), .wb_stb_i(a_stb), .wb_we_i(a_we),
    .wb_adr_i(a_adr), .wb_dat_i(a_dat), .wb_dat_o(a_dat_o), .wb_ack_o(a_ack),
    .reg_addr(a_raddr), .reg_wdata(a_wdata), .reg_we(a_rwe), .reg_re(a_rre),
    .reg_rdata(a_rdata)
  );

  can_wb_reg_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_REGS(32), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_we_i(b_we),
    .wb_adr_i(b_adr), .wb_dat_i(b_dat), .wb_dat_o(b_dat_o), .wb_ack_o(b_ack),
    .reg_addr(b_raddr), .reg_wdata(b_wdata), .reg_we(b_rwe), .reg_re(b_rre),
    .reg_rdata(b_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] we_mask, re_mask, ack_mask;
  int          both_hi;

  initial begin
    rst_n = 1'b0;
    a_cyc = 0; a_stb = 0; a_we = 0; a_adr = '0; a_dat = '0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_adr = '0; b_dat = '0;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_ack",   {31'b0, a_ack}, 0);
    check("rst_dat",   {24'b0, a_dat_o}, 0);
    check("rst_we_re", {30'b0, a_rwe, a_rre}, 0);
    check("rst_addr",  {24'b0, a_raddr}, 0);
    check("rst_wdata", {24'b0, a_wdata}, 0);
    check("rst_w3",    {30'b0, b_ack, b_rwe}, 0);
    rst_n = 1'b1;
    tick();

    // ---------------- write, W=0 ----------------
    a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 8'h04; a_dat = 8'hA5;
    tick();                                   // edge 0
    a_stb = 0;
    check("w0_wr_c1_we",    {31'b0, a_rwe}, 1);
    check("w0_wr_c1_re",    {31'b0, a_rre}, 0);
    check("w0_wr_c1_addr",  {24'b0, a_raddr}, 32'h04);
    check("w0_wr_c1_wdata", {24'b0, a_wdata}, 32'hA5);
    check("w0_wr_c1_ack",   {31'b0, a_ack}, 0);
    tick();
    check("w0_wr_c2_ack",   {31'b0, a_ack}, 1);
    check("w0_wr_c2_we_re", {30'b0, a_rwe, a_rre}, 0);
    check("w0_wr_c2_dat",   {24'b0, a_dat_o}, 0);
    tick();
    a_cyc = 0;
    check("w0_wr_c3_ack",   {31'b0, a_ack}, 0);

    // ---------------- read, W=0 ----------------
    a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 8'h02; a_dat = 8'h00;
    tick();
    a_stb = 0;
    check("w0_rd_c1_re",  {31'b0, a_rre}, 1);
    check("w0_rd_c1_we",  {31'b0, a_rwe}, 0);
    check("w0_rd_c1_ack", {31'b0, a_ack}, 0);
    tick();
    check("w0_rd_c2_ack", {31'b0, a_ack}, 1);
    check("w0_rd_c2_re",  {31'b0, a_rre}, 0);
    check("w0_rd_c2_dat", {24'b0, a_dat_o}, 32'h3C);
    tick();
    a_cyc = 0;
    check("w0_rd_c3_dat", {24'b0, a_dat_o}, 32'h3C);
    tick();
    check("w0_rd_c4_dat", {24'b0, a_dat_o}, 32'h3C);

    // ---------------- unmapped read 0x40 ----------------
    a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 8'h40;
    tick();
    a_stb = 0;
    check("um_rd_c1_re",   {30'b0, a_rwe, a_rre}, 0);
    check("um_rd_c1_addr", {24'b0, a_raddr}, 32'h40);
    tick();
    check("um_rd_c2_ack",  {31'b0, a_ack}, 1);
    check("um_rd_c2_dat",  {24'b0, a_dat_o}, 0);
    tick();
    a_cyc = 0;
    tick();

    // ---------------- unmapped write 0x20 ----------------
    a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 8'h20; a_dat = 8'h5A;
    tick();
    a_stb = 0;
    check("um_wr_c1_we",  {30'b0, a_rwe, a_rre}, 0);
    tick();
    check("um_wr_c2_ack", {31'b0, a_ack}, 1);
    tick();
    a_cyc = 0;
    tick();

    // ---------------- back-to-back reads, stb held ----------------
    // Expect re in cycles 1,4,7 (mask 0x092) and ack in cycles 2,5,8 (0x124).
    a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 8'h05;
    re_mask = '0; ack_mask = '0; we_mask = '0; both_hi = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      re_mask[n]  = a_rre;
      ack_mask[n] = a_ack;
      we_mask[n]  = a_rwe;
      if (a_rre && a_rwe) both_hi++;
      if (n == 8) begin
        a_cyc = 0; a_stb = 0;
      end
    end
    check("b2b_re_mask",  {16'b0, re_mask}, 32'h0092);
    check("b2b_ack_mask", {16'b0, ack_mask}, 32'h0124);
    check("b2b_no_we",    {16'b0, we_mask}, 0);
    check("b2b_not_both", both_hi, 0);
    check("b2b_dat",      {24'b0, a_dat_o}, 32'h5A);

    // ---------------- wait states, W=3: write 0x01 ----------------
    // Expect we in cycle 4 (mask 0x10) and ack in cycle 5 (mask 0x20).
    b_cyc = 1; b_stb = 1; b_we = 1; b_adr = 8'h01; b_dat = 8'h77;
    we_mask = '0; ack_mask = '0;
    tick();
    b_stb = 0;
    for (int n = 1; n <= 7; n++) begin
      we_mask[n]  = b_rwe;
      ack_mask[n] = b_ack;
      if (n == 4) begin
        check("w3_wr_c4_addr",  {24'b0, b_raddr}, 32'h01);
        check("w3_wr_c4_wdata", {24'b0, b_wdata}, 32'h77);
      end
      if (n == 5) b_cyc = 0;
      tick();
    end
    check("w3_wr_we_mask",  {16'b0, we_mask}, 32'h0010);
    check("w3_wr_ack_mask", {16'b0, ack_mask}, 32'h0020);

    // ---------------- W=3: drop cyc during WAIT ----------------
    b_cyc = 1; b_stb = 1; b_we = 1; b_adr = 8'h03; b_dat = 8'h11;
    we_mask = '0; ack_mask = '0;
    tick();
    b_stb = 0;
    tick();                                   // cycle 2, still in WAIT
    b_cyc = 0;
    for (int n = 2; n <= 8; n++) begin
      we_mask[n]  = b_rwe;
      ack_mask[n] = b_ack;
      tick();
    end
    check("w3_abort_no_we",  {16'b0, we_mask}, 0);
    check("w3_abort_no_ack", {16'b0, ack_mask}, 0);
    // IDLE again: a new read gets the normal latency (re cycle 4, ack cycle 5)
    b_cyc = 1; b_stb = 1; b_we = 0; b_adr = 8'h02;
    re_mask = '0; ack_mask = '0;
    tick();
    b_stb = 0;
    for (int n = 1; n <= 6; n++) begin
      re_mask[n]  = b_rre;
      ack_mask[n] = b_ack;
      if (n == 5) check("w3_rd_c5_dat", {24'b0, b_dat_o}, 32'h3C);
      tick();
    end
    b_cyc = 0;
    check("w3_after_abort_re",  {16'b0, re_mask}, 32'h0010);
    check("w3_after_abort_ack", {16'b0, ack_mask}, 32'h0020);
    tick();

    // ---------------- reset during STROBE of a read ----------------
    a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 8'h07;
    tick();                                   // cycle 1: STROBE
    a_stb = 0;
    check("rm_pre_re",  {31'b0, a_rre}, 1);
    check("rm_pre_dat", {24'b0, a_dat_o}, 32'h5A);
    #1 rst_n = 1'b0;
    #1;
    check("rm_async_re",  {31'b0, a_rre}, 0);
    check("rm_async_ack", {31'b0, a_ack}, 0);
    check("rm_async_dat", {24'b0, a_dat_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_mask = '0; re_mask = '0;
    for (int n = 0; n < 5; n++) begin
      tick();
      ack_mask[n] = a_ack;
      re_mask[n]  = a_rre;
    end
    check("rm_no_ack_after", {16'b0, ack_mask}, 0);
    check("rm_no_re_after",  {16'b0, re_mask}, 0);
    a_cyc = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
